asi_arb: RTL

ASI_ARB -- requirements
Module: asi_arb

---
 rtl/asi_arb.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/asi_arb.sv
`default_nettype none
// ============================================================================
//  Module   : asi_arb
//  Purpose  : Burst-level arbiter for NCH requesting channels. A grant is held
//             from the arbitration edge until the owner flags its final beat,
//             then the next winner is chosen with no idle cycle in between.
//             Winner selection is fixed priority, round-robin or weighted
//             round-robin (MODE 0/1/2), with an optional starvation override.
//  Ports    : usr_clk   - single clock, rising edge
//             usr_reset - synchronous active-high reset
//             req       - per-channel burst pending level
//             last      - per-channel final beat (only owner's bit is used)
//             weight    - per-channel burst quota for MODE 2 (WGT_W each)
//             gnt       - registered one-hot grant
//             gnt_idx   - registered binary index of the grant (0 when idle)
//             gnt_v     - registered "some channel granted"
//             starve    - registered per-channel starvation flag
//  Revision : 1.0 - initial release
// ============================================================================
module asi_arb #(
  parameter int NCH        = 2,
  parameter int MODE       = 1,
  parameter int WGT_W      = 4,
  parameter int STARVE_LIM = 0,
  parameter int IDXW       = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic                   usr_clk,
  input  logic                   usr_reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         last,
  input  logic [NCH*WGT_W-1:0]   weight,
  output logic [NCH-1:0]         gnt,
  output logic [IDXW-1:0]        gnt_idx,
  output logic                   gnt_v,
  output logic [NCH-1:0]         starve
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;

  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   ptr_nx;
  logic [WGT_W-1:0]  credit [NCH];
  logic [WGT_W-1:0]  reload [NCH];

  logic [NCH-1:0]    starve_req;
  logic              owner_valid;
  logic              keep_owner;
  logic              regrant;
  logic [IDXW-1:0]   win;
  logic              arb;
  logic [NCH-1:0]    gnt_nx;
  logic [IDXW-1:0]   idx_nx;

  // Lowest-index set bit of a request vector.
  function automatic logic [IDXW-1:0] lowest(input logic [NCH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction

  // First set bit at or above position p, wrapping past the top channel.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NCH-1:0] v,
                                              input logic [IDXW-1:0] p);
    logic            found;
    logic [IDXW-1:0] r;
    int              c;
    found = 1'b0;
    r     = '0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(p) + k) % NCH;
      if (!found && v[c]) begin
        found = 1'b1;
        r     = IDXW'(c);
      end
    end
    return r;
  endfunction

  // A zero quota would never let a channel be granted twice in a row anyway,
  // so it is treated as a quota of one burst.
  for (genvar i = 0; i < NCH; i++) begin : g_reload
    assign reload[i] = (weight[i*WGT_W +: WGT_W] == '0) ? WGT_W'(1)
                                                         : weight[i*WGT_W +: WGT_W];
  end

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  always_comb begin
    starve_req  = starve & req;
    owner_valid = (state == GRANT);
    keep_owner  = (MODE == 2) && owner_valid && req[gnt_idx] &&
                  (credit[gnt_idx] > WGT_W'(1));
    regrant     = 1'b0;
    if (|starve_req) begin
      win = lowest(starve_req);
    end else if (MODE == 0) begin
      win = lowest(req);
    end else if (keep_owner) begin
      win     = gnt_idx;
      regrant = 1'b1;
    end else begin
      win = rr_pick(req, ptr);
    end
    ptr_nx = (int'(win) == NCH - 1) ? '0 : win + IDXW'(1);
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next grant
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    arb      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          arb      = 1'b1;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (last[gnt_idx]) begin
          if (|req) begin
            arb = 1'b1;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            idx_nx   = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
    if (arb) begin
      gnt_nx      = '0;
      gnt_nx[win] = 1'b1;
      idx_nx      = win;
    end
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) state <= IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_v   <= 1'b0;
      ptr     <= '0;
    end else begin
      gnt     <= gnt_nx;
      gnt_idx <= idx_nx;
      gnt_v   <= |gnt_nx;
      if (arb) ptr <= ptr_nx;
    end
  end

  // Credits: only the outgoing owner's counter moves at an arbitration.
  // It is consumed on a re-grant and refilled when the owner gives way.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      for (int i = 0; i < NCH; i++) credit[i] <= reload[i];
    end else if ((MODE == 2) && arb && owner_valid) begin
      if (regrant) credit[gnt_idx] <= credit[gnt_idx] - WGT_W'(1);
      else         credit[gnt_idx] <= reload[gnt_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Starvation tracking
  // --------------------------------------------------------------------------
  if (STARVE_LIM > 0) begin : g_starve
    localparam int            CW  = ($clog2(STARVE_LIM + 1) > 1) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] wait_cnt;
      logic [CW-1:0] wait_nx;
      logic          flag;

      // A channel winning on this edge counts as granted, so its flag drops
      // together with the grant rising and cannot win a second time.
      always_comb begin
        wait_nx = '0;
        if (req[i] && !gnt[i] && !gnt_nx[i]) begin
          wait_nx = (wait_cnt == LIM) ? LIM : wait_cnt + CW'(1);
        end
      end

      always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
          wait_cnt <= '0;
          flag     <= 1'b0;
        end else begin
          wait_cnt <= wait_nx;
          flag     <= (wait_nx == LIM);
        end
      end

      assign starve[i] = flag;
    end
  end else begin : g_no_starve
    assign starve = '0;
  end

endmodule
`default_nettype wire
